line_steer_ctrl: RTL and testbench
==================================

Name: line_steer_ctrl

Overview:
- Consumes the per-frame line-tracker result (`centroid_x`, `line_valid`, `line_lost`) and closes the steering loop.
- Computes a proportional steering command from the centroid error and drives a servo PWM and a motor PWM.
- Runs a tracking / coast / search / stop state machine for line-loss recovery.
- Sits between the centroid tracker and the DE2 GPIO servo/motor pins.

Parameters:
- IMG_W, 640, image width; centre reference = IMG_W/2.
- KP, 3, proportional gain multiplier (unsigned).
- KP_SHIFT, 1, arithmetic right shift applied after multiply.
- STEER_MAX, 255, clamp magnitude of steer_cmd.
- STEER_GAIN_SHIFT, 6, steer_cmd to servo pulse clocks: steer_cmd <<< shift.
- PWM_PERIOD, 1000000, servo period in clk cycles (20 ms @ 50 MHz).
- PWM_CENTER, 75000, neutral servo pulse width in clocks (1.5 ms).
- TRACK_SPEED, 180, motor duty (of 256) in TRACK.
- COAST_SPEED, 120, motor duty in COAST.
- SEARCH_SPEED, 80, motor duty in SEARCH.
- SEARCH_STEER, 200, steer magnitude used while searching.
- LOST_COAST_FRAMES, 3, consecutive lost frames before SEARCH.
- SEARCH_FRAMES, 30, further lost frames before STOP.
- SLEW_MAX, 32, max steer_cmd change per frame (STEER_SLEW_EN only).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  run enable; low forces IDLE.
- centroid_x  in  11  frame centroid, unsigned, 0..IMG_W-1.
- line_valid  in  1  result-valid level; may be held high for several cycles.
- line_lost  in  1  no line found; qualified by line_valid.
- steer_cmd  out  10  signed steering command, range ±STEER_MAX.
- steer_pwm  out  1  servo pulse.
- motor_pwm  out  1  motor PWM, period 256 clk.
- state_o  out  3  current FSM state encoding.
- frame_tick  out  1  one-cycle pulse when a new result is consumed.

Behaviour:
- Reset values: steer_cmd=0, steer_pwm=0, motor_pwm=0, state_o=IDLE, frame_tick=0.
- Reset also clears: all counters, lost_cnt, last_dir (right).
- Event detect: event = line_valid & ~line_valid_d. Exactly one update per valid assertion, regardless of hold length. frame_tick = event, registered (1-cycle latency).
- Error path, on a non-lost event:
  - err = signed(centroid_x) - IMG_W/2, 12-bit signed.
  - p = (err*KP) >>> KP_SHIFT, 16-bit signed, floor rounding.
  - Clamp p to ±STEER_MAX.
  - Register steer_cmd one cycle after the event.
  - last_dir = (err>=0) ? right : left.
- States: IDLE, TRACK, COAST, SEARCH, STOP.
  - IDLE: steer 0, motor 0. Exits to TRACK on the first non-lost event while enable=1.
  - TRACK: steer from P path; motor duty TRACK_SPEED. A lost event sets lost_cnt=1 and goes to COAST.
  - COAST: steer_cmd held; motor duty COAST_SPEED. Each lost event increments lost_cnt. lost_cnt==LOST_COAST_FRAMES goes to SEARCH.
  - SEARCH: steer_cmd = +SEARCH_STEER if last_dir right, else -SEARCH_STEER; motor duty SEARCH_SPEED. lost_cnt reaching LOST_COAST_FRAMES+SEARCH_FRAMES goes to STOP.
  - STOP: steer 0, motor 0.
  - Any non-lost event in COAST, SEARCH or STOP goes to TRACK, clears lost_cnt, and applies the P update in the same transition.
- Counter rules:
  - lost_cnt saturates at LOST_COAST_FRAMES+SEARCH_FRAMES.
  - Only events change lost_cnt.
- Lost takes priority: line_valid with line_lost=1 is a lost event; centroid_x is ignored.
- enable=0: next cycle go to IDLE, steer_cmd=0, PWMs low after the current period ends. Re-enable waits for a non-lost event.
- Servo PWM:
  - Counter 0..PWM_PERIOD-1 (20-bit).
  - Compare value = PWM_CENTER + (steer_cmd <<< STEER_GAIN_SHIFT), latched only at counter==0 (glitch-free).
  - steer_pwm = counter < latched compare.
  - In IDLE, the servo still emits the PWM_CENTER pulse.
- Motor PWM: 8-bit free-running counter; motor_pwm = cnt < duty. Duty 0 gives a constant low output.
- Reset mid-period: both PWMs drop low on the cycle after rst; counters restart at 0.

Optional Feature:
- Macro: STEER_SLEW_EN.
- With the macro defined: each P update or SEARCH entry moves steer_cmd toward its target by at most SLEW_MAX per event. The STOP/IDLE forced 0 is applied immediately.
- Without the macro: steer_cmd takes the target directly.

Decomposition:
- Package line_ctrl_pkg:
  - state enum (IDLE=0, TRACK=1, COAST=2, SEARCH=3, STOP=4).
  - Steer width constant (10).
  - Error width constant (12).
  - PWM counter width constants.
- Sub-module pwm_gen (parameterised period/width, compare latched at wrap), instantiated twice: servo and motor.

Test Plan:
- Reset, enable=1, one event with centroid_x=400, lost=0:
  - Expect TRACK.
  - err=80, steer_cmd=120 one cycle after the event.
  - Next servo pulse high 75000+120*64=82680 clocks.
  - motor high 180/256 clocks.
- centroid_x=639 then centroid_x=0 events: steer_cmd=+255 then -255 (clamped; raw 478 and -480).
- line_valid held high 8 cycles: frame_tick pulses exactly once; lost_cnt or steer updated once.
- From TRACK with last err=+80, apply 3 lost events:
  - COAST with steer held 120.
  - At 3rd event, SEARCH, steer_cmd=+200, motor duty 80.
  - 30 more lost events give STOP, steer 0, motor_pwm constant 0.
  - Then a non-lost event at centroid_x=320 gives TRACK, steer 0.
- Assert rst mid servo pulse during SEARCH:
  - Next cycle all outputs at reset values, state IDLE.
  - A lost event while in IDLE is ignored.
- STEER_SLEW_EN build: from steer 0, event centroid_x=639 gives steer_cmd 32, 64, 96 … over successive events until 255.

Source files
------------

// File: rtl/line_ctrl_pkg.sv
// Shared types and widths for the line-following steering controller.
// Optional build macro used by the controller: STEER_SLEW_EN (per-event slew limit on steer_cmd).
package line_ctrl_pkg;

   // Controller state encoding, also exported on state_o
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      TRACK  = 3'd1,
      COAST  = 3'd2,
      SEARCH = 3'd3,
      STOP   = 3'd4
   } state_e;

   localparam int STEER_W     = 10;  // signed steering command
   localparam int ERR_W       = 12;  // signed centroid error
   localparam int P_W         = 16;  // signed proportional term before clamping
   localparam int CX_W        = 11;  // unsigned centroid coordinate
   localparam int LOST_W      = 8;   // lost-frame counter
   localparam int SERVO_CNT_W = 20;  // servo period counter (20 ms at 50 MHz)
   localparam int MOTOR_CNT_W = 8;   // motor period counter (256 clocks)

   // Move cur toward tgt by at most max_step; lands exactly on tgt when close enough
   function automatic logic signed [STEER_W-1:0] slew_step(
      input logic signed [STEER_W-1:0] cur,
      input logic signed [STEER_W-1:0] tgt,
      input int unsigned               max_step
   );
      logic signed [STEER_W:0] diff;
      logic signed [STEER_W:0] lim;
      diff = $signed({tgt[STEER_W-1], tgt}) - $signed({cur[STEER_W-1], cur});
      lim  = $signed((STEER_W+1)'(max_step));
      if (diff > lim)
         slew_step = cur + STEER_W'(max_step);
      else if (diff < -lim)
         slew_step = cur - STEER_W'(max_step);
      else
         slew_step = tgt;
   endfunction

endpackage

// File: rtl/line_steer_ctrl_if.sv
// Tracker-result inputs and actuator/status outputs of the steering controller.
// Handshake: there is no ready. line_valid is a level; the controller consumes one
// result on each rising edge of line_valid (centroid_x/line_lost sampled on that
// cycle) and acknowledges it with a one-cycle frame_tick on the following cycle.
interface line_steer_ctrl_if
   import line_ctrl_pkg::*;
;
   logic                      enable;
   logic [CX_W-1:0]           centroid_x;
   logic                      line_valid;
   logic                      line_lost;
   logic signed [STEER_W-1:0] steer_cmd;
   logic                      steer_pwm;
   logic                      motor_pwm;
   logic [2:0]                state_o;
   logic                      frame_tick;

   // Tracker / test side drives results, reads actuator and status
   modport master (
      output enable, centroid_x, line_valid, line_lost,
      input  steer_cmd, steer_pwm, motor_pwm, state_o, frame_tick
   );

   // Controller side
   modport slave (
      input  enable, centroid_x, line_valid, line_lost,
      output steer_cmd, steer_pwm, motor_pwm, state_o, frame_tick
   );
endinterface

// File: rtl/line_steer_ctrl_pwm_gen.sv
// Generic PWM: free-running counter 0..PERIOD-1, compare value latched at counter 0
// so a mid-period compare change never produces a runt pulse. Output is registered.
module pwm_gen #(
   parameter int PERIOD = 256,
   parameter int W      = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] cmp,
   output logic         pwm_out
);

   logic [W-1:0] cnt;
   logic [W-1:0] cmp_q;
   logic [W-1:0] cmp_eff;

   // At counter 0 the fresh compare is used directly; elsewhere the latched copy
   always_comb begin
      cmp_eff = (cnt == '0) ? cmp : cmp_q;
   end

   // Period counter, compare latch and registered output
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         cmp_q   <= '0;
         pwm_out <= 1'b0;
      end else begin
         cnt     <= (cnt == W'(PERIOD - 1)) ? '0 : cnt + 1'b1;
         if (cnt == '0)
            cmp_q <= cmp;
         pwm_out <= (cnt < cmp_eff);
      end
   end

endmodule

// File: rtl/line_steer_ctrl.sv
// Line-following steering controller: proportional steering from the frame centroid,
// TRACK/COAST/SEARCH/STOP line-loss recovery, servo and motor PWM generation.
// Optional build macro: STEER_SLEW_EN limits steer_cmd change to SLEW_MAX per event.
module line_steer_ctrl
   import line_ctrl_pkg::*;
#(
   parameter int IMG_W             = 640,
   parameter int KP                = 3,
   parameter int KP_SHIFT          = 1,
   parameter int STEER_MAX         = 255,
   parameter int STEER_GAIN_SHIFT  = 6,
   parameter int PWM_PERIOD        = 1000000,
   parameter int PWM_CENTER        = 75000,
   parameter int TRACK_SPEED       = 180,
   parameter int COAST_SPEED       = 120,
   parameter int SEARCH_SPEED      = 80,
   parameter int SEARCH_STEER      = 200,
   parameter int LOST_COAST_FRAMES = 3,
   parameter int SEARCH_FRAMES     = 30
`ifdef STEER_SLEW_EN
   ,parameter int SLEW_MAX         = 32
`endif
) (
   input  logic clk,
   input  logic rst,
   line_steer_ctrl_if.slave bus
);

   localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(LOST_COAST_FRAMES + SEARCH_FRAMES);

   state_e                    state_q, state_d;
   logic [LOST_W-1:0]         lost_q, lost_d, lost_inc;
   logic                      dir_left_q, dir_left_d;
   logic signed [STEER_W-1:0] steer_q, steer_d, tgt, p_clamp, search_tgt;
   logic                      valid_d, tick_q;
   logic                      evt, good_evt, lost_evt;
   logic                      upd, force_zero;
   logic signed [ERR_W-1:0]   err;
   logic signed [P_W-1:0]     prod, p;
   logic [SERVO_CNT_W-1:0]    steer_ext, servo_cmp;
   logic [MOTOR_CNT_W-1:0]    duty;

   assign evt      = bus.line_valid & ~valid_d;
   assign good_evt = evt & ~bus.line_lost;
   assign lost_evt = evt & bus.line_lost;
   assign lost_inc = (lost_q >= LOST_MAX) ? lost_q : lost_q + 1'b1;
   assign search_tgt = dir_left_q ? -$signed(STEER_W'(SEARCH_STEER)) : $signed(STEER_W'(SEARCH_STEER));

   // Proportional path: centre error, gain, floor shift, symmetric clamp
   always_comb begin
      err  = $signed({1'b0, bus.centroid_x}) - $signed(ERR_W'(IMG_W / 2));
      prod = $signed({{(P_W-ERR_W){err[ERR_W-1]}}, err}) * $signed(P_W'(KP));
      p    = prod >>> KP_SHIFT;
      if (p > $signed(P_W'(STEER_MAX)))
         p_clamp = $signed(STEER_W'(STEER_MAX));
      else if (p < -$signed(P_W'(STEER_MAX)))
         p_clamp = -$signed(STEER_W'(STEER_MAX));
      else
         p_clamp = STEER_W'(p);
   end

   // Next state, lost counter, direction memory and steering target selection
   always_comb begin
      state_d    = state_q;
      lost_d     = lost_q;
      dir_left_d = dir_left_q;
      upd        = 1'b0;
      force_zero = 1'b0;
      tgt        = steer_q;
      if (!bus.enable) begin
         state_d    = IDLE;
         lost_d     = '0;
         force_zero = 1'b1;
      end else if (good_evt) begin
         state_d    = TRACK;
         lost_d     = '0;
         upd        = 1'b1;
         tgt        = p_clamp;
         dir_left_d = err[ERR_W-1];
      end else if (lost_evt) begin
         case (state_q)
            TRACK: begin
               state_d = COAST;
               lost_d  = LOST_W'(1);
            end
            COAST: begin
               lost_d = lost_inc;
               if (lost_inc == LOST_W'(LOST_COAST_FRAMES)) begin
                  state_d = SEARCH;
                  upd     = 1'b1;
                  tgt     = search_tgt;
               end
            end
            SEARCH: begin
               lost_d = lost_inc;
               if (lost_inc >= LOST_MAX) begin
                  state_d    = STOP;
                  force_zero = 1'b1;
               end else begin
                  upd = 1'b1;
                  tgt = search_tgt;
               end
            end
            STOP: begin
               lost_d     = lost_inc;
               force_zero = 1'b1;
            end
            default: ;  // IDLE waits for a real line
         endcase
      end
   end

   // Steering register update: forced zero wins, otherwise follow target (optionally slewed)
   always_comb begin
      steer_d = steer_q;
      if (force_zero)
         steer_d = '0;
      else if (upd) begin
`ifdef STEER_SLEW_EN
         steer_d = slew_step(steer_q, tgt, SLEW_MAX);
`else
         steer_d = tgt;
`endif
      end
   end

   // Motor duty follows the current state
   always_comb begin
      case (state_q)
         TRACK:   duty = MOTOR_CNT_W'(TRACK_SPEED);
         COAST:   duty = MOTOR_CNT_W'(COAST_SPEED);
         SEARCH:  duty = MOTOR_CNT_W'(SEARCH_SPEED);
         default: duty = '0;
      endcase
   end

   // Servo compare: neutral pulse plus scaled steering, two's-complement modulo counter width
   always_comb begin
      steer_ext = {{(SERVO_CNT_W-STEER_W){steer_q[STEER_W-1]}}, steer_q};
      servo_cmp = SERVO_CNT_W'(PWM_CENTER) + (steer_ext << STEER_GAIN_SHIFT);
   end

   // State, counters, steering and event-edge registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         lost_q     <= '0;
         dir_left_q <= 1'b0;
         steer_q    <= '0;
         valid_d    <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lost_q     <= lost_d;
         dir_left_q <= dir_left_d;
         steer_q    <= steer_d;
         valid_d    <= bus.line_valid;
         tick_q     <= evt;
      end
   end

   pwm_gen #(.PERIOD(PWM_PERIOD), .W(SERVO_CNT_W)) u_servo_pwm (
      .clk(clk), .rst(rst), .cmp(servo_cmp), .pwm_out(bus.steer_pwm)
   );

   pwm_gen #(.PERIOD(256), .W(MOTOR_CNT_W)) u_motor_pwm (
      .clk(clk), .rst(rst), .cmp(duty), .pwm_out(bus.motor_pwm)
   );

   assign bus.steer_cmd  = steer_q;
   assign bus.state_o    = state_q;
   assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_line_steer_ctrl.sv
// Directed bench for line_steer_ctrl. Servo period shortened (2400 clk, centre 1100,
// gain shift 2) so pulse widths can be measured quickly; other parameters default.
module tb_line_steer_ctrl;
   import line_ctrl_pkg::*;

   localparam int SW = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   int   tick_cnt = 0;
   int   w;
   int   t0;
   int   n;
   logic [SW-1:0] exp_q[$];
   logic [SW-1:0] mon_e;

   line_steer_ctrl_if bus();

   line_steer_ctrl #(
      .PWM_PERIOD(2400), .PWM_CENTER(1100), .STEER_GAIN_SHIFT(2)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp_v, exp_v);
   endtask

   // scoreboard: each frame_tick must match the next queued steering value
   always @(negedge clk) begin
      if (!rst && bus.frame_tick) begin
         tick_cnt++;
         if (exp_q.size() == 0)
            chk("tick_unexpected", 32'd1, 32'd0);
         else begin
            mon_e = exp_q.pop_front();
            chk("steer", {22'b0, bus.steer_cmd}, {22'b0, mon_e});
         end
      end
   end

   function automatic logic sig(input int sel);
      return (sel != 0) ? bus.motor_pwm : bus.steer_pwm;
   endfunction

   task automatic send_evt(input int cx, input bit lost, input int exp_steer, input int hold);
      exp_q.push_back(SW'(exp_steer));
      @(posedge clk); #1;
      bus.centroid_x = 11'(cx);
      bus.line_lost  = lost;
      bus.line_valid = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      bus.line_valid = 1'b0;
      bus.line_lost  = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   // width of the next complete high pulse (-1 on timeout)
   task automatic measure_high(input int sel, input int bound, output int width);
      int k;
      k = 0;
      width = 0;
      @(negedge clk);
      while (sig(sel) == 1'b1 && k < bound) begin @(negedge clk); k++; end
      while (sig(sel) == 1'b0 && k < bound) begin @(negedge clk); k++; end
      if (k >= bound) begin
         width = -1;
         return;
      end
      while (sig(sel) == 1'b1 && width < bound) begin width++; @(negedge clk); end
   endtask

   task automatic count_high(input int sel, input int cycles, output int hi);
      hi = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (sig(sel)) hi++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_steer"},     {22'b0, bus.steer_cmd}, 32'd0);
      chk({tag, "_steer_pwm"}, 32'(bus.steer_pwm),     32'd0);
      chk({tag, "_motor_pwm"}, 32'(bus.motor_pwm),     32'd0);
      chk({tag, "_state"},     32'(bus.state_o),       32'(IDLE));
      chk({tag, "_tick"},      32'(bus.frame_tick),    32'd0);
   endtask

   initial begin
      bus.enable     = 1'b1;
      bus.line_valid = 1'b0;
      bus.line_lost  = 1'b0;
      bus.centroid_x = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1 rst = 1'b0;

`ifdef STEER_SLEW_EN
      // slewed approach to +255 from 0
      for (int i = 1; i <= 7; i++) send_evt(639, 1'b0, 32 * i, 1);
      send_evt(639, 1'b0, 255, 1);
      chk("slew_state_track", 32'(bus.state_o), 32'(TRACK));
      send_evt(0, 1'b1, 255, 1);
      send_evt(0, 1'b1, 255, 1);
      send_evt(0, 1'b1, 223, 1);
      chk("slew_state_search", 32'(bus.state_o), 32'(SEARCH));
      send_evt(0, 1'b1, 200, 1);
      @(posedge clk); #1 bus.enable = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("slew_disable_steer", {22'b0, bus.steer_cmd}, 32'd0);
      chk("slew_disable_state", 32'(bus.state_o), 32'(IDLE));
`else
      // first tracked frame: err=80 -> 120
      send_evt(400, 1'b0, 120, 1);
      chk("state_track", 32'(bus.state_o), 32'(TRACK));
      measure_high(0, 6000, w);
      chk("servo_120", w, 32'd1580);
      measure_high(1, 600, w);
      chk("motor_track", w, 32'd180);

      // clamp at both image edges
      send_evt(639, 1'b0, 255, 1);
      send_evt(0, 1'b0, -255, 1);
      measure_high(0, 6000, w);
      chk("servo_m255", w, 32'd80);

      // held valid: one update only
      t0 = tick_cnt;
      send_evt(400, 1'b0, 120, 8);
      chk("tick_once", tick_cnt - t0, 32'd1);

      // line loss: coast, coast, search
      send_evt(500, 1'b1, 120, 1);
      chk("state_coast1", 32'(bus.state_o), 32'(COAST));
      send_evt(0, 1'b1, 120, 1);
      chk("state_coast2", 32'(bus.state_o), 32'(COAST));
      send_evt(0, 1'b1, 200, 1);
      chk("state_search", 32'(bus.state_o), 32'(SEARCH));
      measure_high(1, 600, w);
      chk("motor_search", w, 32'd80);
      measure_high(0, 6000, w);
      chk("servo_search", w, 32'd1900);

      // 30 more lost frames reach STOP
      for (int i = 0; i < 29; i++) send_evt(0, 1'b1, 200, 1);
      chk("state_search_29", 32'(bus.state_o), 32'(SEARCH));
      send_evt(0, 1'b1, 0, 1);
      chk("state_stop", 32'(bus.state_o), 32'(STOP));
      repeat (260) @(negedge clk);
      count_high(1, 300, w);
      chk("motor_stop_low", w, 32'd0);

      // recovery at image centre
      send_evt(320, 1'b0, 0, 1);
      chk("state_recover", 32'(bus.state_o), 32'(TRACK));

      // back into SEARCH, then reset in the middle of a servo pulse
      send_evt(0, 1'b1, 0, 1);
      send_evt(0, 1'b1, 0, 1);
      send_evt(0, 1'b1, 200, 1);
      chk("state_search_b", 32'(bus.state_o), 32'(SEARCH));
      n = 0;
      while (!bus.steer_pwm && n < 6000) begin @(negedge clk); n++; end
      chk("servo_pulse_seen", 32'(bus.steer_pwm), 32'd1);
      repeat (10) @(negedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check_reset_outputs("midrst");
      @(posedge clk); #1 rst = 1'b0;

      // lost frame in IDLE is ignored
      send_evt(400, 1'b1, 0, 1);
      chk("idle_lost_ignored", 32'(bus.state_o), 32'(IDLE));

      // enable low forces IDLE and zero steering
      send_evt(400, 1'b0, 120, 1);
      chk("state_track_b", 32'(bus.state_o), 32'(TRACK));
      @(posedge clk); #1 bus.enable = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("disable_state", 32'(bus.state_o), 32'(IDLE));
      chk("disable_steer", {22'b0, bus.steer_cmd}, 32'd0);
      send_evt(639, 1'b0, 0, 1);
      chk("disable_evt_idle", 32'(bus.state_o), 32'(IDLE));
      repeat (260) @(negedge clk);
      count_high(1, 300, w);
      chk("disable_motor_low", w, 32'd0);
`endif

      repeat (2) @(negedge clk);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
